// File: rtl/alu_181.sv
// alu_181: registered 4-bit ALU slice with the full 74181 function set (16 logic, 16 arithmetic).
// Define ALU181_INREG_EN to add an input register stage in front of the output stage (2-cycle latency).
module alu_181 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       C0,
   input  logic       M,
   input  logic [3:0] S,
   output logic [3:0] F,
   output logic       C4,
   output logic       AequB,
   output logic       P,
   output logic       G
);

   // Operands feeding the function logic: either the raw ports or the input stage.
   logic [3:0] a_op;
   logic [3:0] b_op;
   logic [3:0] s_op;
   logic       c0_op;
   logic       m_op;

`ifdef ALU181_INREG_EN
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [3:0] s_q;
   logic       c0_q;
   logic       m_q;

   // Reset leaves the input stage holding a harmless logic-mode operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= 4'b0000;
         b_q  <= 4'b0000;
         c0_q <= 1'b1;
         m_q  <= 1'b1;
         s_q  <= 4'b0000;
      end else begin
         a_q  <= A;
         b_q  <= B;
         c0_q <= C0;
         m_q  <= M;
         s_q  <= S;
      end
   end

   assign a_op  = a_q;
   assign b_op  = b_q;
   assign c0_op = c0_q;
   assign m_op  = m_q;
   assign s_op  = s_q;
`else
   assign a_op  = A;
   assign b_op  = B;
   assign c0_op = C0;
   assign m_op  = M;
   assign s_op  = S;
`endif

   logic [3:0] x;
   logic [3:0] y;
   logic [4:0] sum;
   logic [3:0] f_d;
   logic       c4_d;
   logic       aequb_d;
   logic       p_d;
   logic       g_d;

   // NOTE: every signal is given a default at the top of the block so no path can infer a latch.
   always_comb begin
      x       = a_op | (b_op & {4{s_op[0]}}) | (~b_op & {4{s_op[1]}});
      y       = (a_op & b_op & {4{s_op[3]}}) | (a_op & ~b_op & {4{s_op[2]}});
      sum     = {1'b0, x} + {1'b0, y} + {4'b0000, ~c0_op};
      f_d     = sum[3:0];
      c4_d    = ~sum[4];
      if (m_op) begin
         f_d  = ~(x ^ y);
         c4_d = 1'b1;
      end
      aequb_d = &f_d;
      // Y is a subset of X, so Y acts as the per-bit generate and X as propagate.
      p_d     = ~(&x);
      g_d     = ~(y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]));
   end

   logic [3:0] f_q;
   logic       c4_q;
   logic       aequb_q;
   logic       p_q;
   logic       g_q;

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_q     <= 4'b0000;
         c4_q    <= 1'b1;
         aequb_q <= 1'b0;
         p_q     <= 1'b1;
         g_q     <= 1'b1;
      end else begin
         f_q     <= f_d;
         c4_q    <= c4_d;
         aequb_q <= aequb_d;
         p_q     <= p_d;
         g_q     <= g_d;
      end
   end

   assign F     = f_q;
   assign C4    = c4_q;
   assign AequB = aequb_q;
   assign P     = p_q;
   assign G     = g_q;

endmodule

// File: tb/tb_alu_181.sv
// tb_alu_181: directed and randomized checks of alu_181 against a function-table reference model.
// Follows ALU181_INREG_EN to pick the expected latency.
module tb_alu_181;

`ifdef ALU181_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       c0;
      logic       m;
      logic [3:0] s;
   } in_t;

   typedef struct packed {
      logic [3:0] f;
      logic       c4;
      logic       aeq;
      logic       p;
      logic       g;
   } exp_t;

   localparam in_t  RST_IN  = '{a: 4'h0, b: 4'h0, c0: 1'b1, m: 1'b1, s: 4'h0};
   localparam exp_t RST_OUT = '{f: 4'h0, c4: 1'b1, aeq: 1'b0, p: 1'b1, g: 1'b1};

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       C0;
   logic       M;
   logic [3:0] S;
   logic [3:0] F;
   logic       C4;
   logic       AequB;
   logic       P;
   logic       G;

   int errors = 0;
   int checks = 0;

   exp_t out_exp;
   in_t  in_q;

   alu_181 dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .C0    (C0),
      .M     (M),
      .S     (S),
      .F     (F),
      .C4    (C4),
      .AequB (AequB),
      .P     (P),
      .G     (G)
   );

   always #5 clk = ~clk;

   // Reference model: the named 74181 function table, plus X/Y for the lookahead pins.
   function automatic exp_t model(input in_t v);
      exp_t       e;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] nb;
      logic [3:0] x;
      logic [3:0] y;
      int         sum;
      a  = v.a;
      b  = v.b;
      nb = ~v.b;
      case (v.s[1:0])
         2'd0:    x = a;
         2'd1:    x = a | b;
         2'd2:    x = a | nb;
         default: x = 4'hF;
      endcase
      case (v.s[3:2])
         2'd0:    y = 4'h0;
         2'd1:    y = a & nb;
         2'd2:    y = a & b;
         default: y = a;
      endcase
      e.p = (x != 4'hF);
      e.g = !((int'(x) + int'(y)) >= 16);
      sum = 0;
      if (v.m) begin
         case (v.s)
            4'd0:    e.f = ~a;
            4'd1:    e.f = ~(a | b);
            4'd2:    e.f = nb & ~(~b & ~a) & ~a | (~a & b);
            4'd3:    e.f = 4'h0;
            4'd4:    e.f = ~(a & b);
            4'd5:    e.f = nb;
            4'd6:    e.f = a ^ b;
            4'd7:    e.f = a & nb;
            4'd8:    e.f = ~a | b;
            4'd9:    e.f = ~(a ^ b);
            4'd10:   e.f = b;
            4'd11:   e.f = a & b;
            4'd12:   e.f = 4'hF;
            4'd13:   e.f = a | nb;
            4'd14:   e.f = a | b;
            default: e.f = a;
         endcase
         e.c4 = 1'b1;
      end else begin
         case (v.s)
            4'd0:    sum = int'(a);
            4'd1:    sum = int'(a | b);
            4'd2:    sum = int'(a | nb);
            4'd3:    sum = 15;
            4'd4:    sum = int'(a) + int'(a & nb);
            4'd5:    sum = int'(a | b) + int'(a & nb);
            4'd6:    sum = int'(a) + (15 - int'(b));
            4'd7:    sum = int'(a & nb) + 15;
            4'd8:    sum = int'(a) + int'(a & b);
            4'd9:    sum = int'(a) + int'(b);
            4'd10:   sum = int'(a | nb) + int'(a & b);
            4'd11:   sum = int'(a & b) + 15;
            4'd12:   sum = int'(a) + int'(a);
            4'd13:   sum = int'(a | b) + int'(a);
            4'd14:   sum = int'(a | nb) + int'(a);
            default: sum = int'(a) + 15;
         endcase
         sum  = sum + (v.c0 ? 0 : 1);
         e.f  = sum[3:0];
         e.c4 = !(sum >= 16);
      end
      e.aeq = (e.f == 4'hF);
      return e;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive on the falling edge, advance the model on the rising edge, sample 1 ns later.
   task automatic step(input in_t v, input logic r);
      @(negedge clk);
      A   = v.a;
      B   = v.b;
      C0  = v.c0;
      M   = v.m;
      S   = v.s;
      rst = r;
      @(posedge clk);
      if (r) begin
         out_exp = RST_OUT;
         in_q    = RST_IN;
      end else if (LAT == 2) begin
         out_exp = model(in_q);
         in_q    = v;
      end else begin
         out_exp = model(v);
      end
      #1;
      check("model_F", {4'b0000, F}, {4'b0000, out_exp.f});
      check("model_flags", {4'b0000, C4, AequB, P, G},
            {4'b0000, out_exp.c4, out_exp.aeq, out_exp.p, out_exp.g});
   endtask

   // Hold one operation for the full latency, then compare with hand-derived constants.
   task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic c0, input logic m, input logic [3:0] s,
                           input logic [3:0] ef, input logic ec4, input logic eaeq,
                           input logic ep, input logic eg);
      in_t v;
      v = '{a: a, b: b, c0: c0, m: m, s: s};
      repeat (LAT) step(v, 1'b0);
      check({tag, "_F"}, {4'b0000, F}, {4'b0000, ef});
      check({tag, "_flags"}, {4'b0000, C4, AequB, P, G}, {4'b0000, ec4, eaeq, ep, eg});
   endtask

   initial begin
      in_t         v;
      logic [31:0] r;
      logic        r_rst;
      v       = RST_IN;
      in_q    = RST_IN;
      out_exp = RST_OUT;
      rst     = 1'b1;
      A       = 4'h0;
      B       = 4'h0;
      C0      = 1'b1;
      M       = 1'b1;
      S       = 4'h0;

      step('{a: 4'h9, b: 4'h3, c0: 1'b0, m: 1'b0, s: 4'h9}, 1'b1);
      step('{a: 4'h9, b: 4'h3, c0: 1'b0, m: 1'b0, s: 4'h9}, 1'b1);
      check("reset_F", {4'b0000, F}, 8'h00);
      check("reset_flags", {4'b0000, C4, AequB, P, G}, 8'h0B);

      directed("add",        4'd5, 4'd7, 1'b1, 1'b0, 4'b1001, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b1);
      directed("add_cin",    4'd5, 4'd7, 1'b0, 1'b0, 4'b1001, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b1);
      directed("sub",        4'd7, 4'd5, 1'b0, 1'b0, 4'b0110, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      directed("sub_borrow", 4'd5, 4'd7, 1'b1, 1'b0, 4'b0110, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b1);
      directed("logic_xor",  4'd5, 4'd7, 1'b1, 1'b1, 4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1);
      directed("logic_nota", 4'd5, 4'd7, 1'b0, 1'b1, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b1);
      directed("logic_and",  4'd5, 4'd7, 1'b1, 1'b1, 4'b1011, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
      directed("minus_one",  4'd9, 4'd3, 1'b1, 1'b0, 4'b0011, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1);
      directed("a_eq_b",     4'd6, 4'd6, 1'b1, 1'b0, 4'b0110, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1);

      // Sweep: C0 flips every cycle, M every 2, S every 4; reset pulsed mid-way.
      for (int k = 0; k < 64; k++) begin
         v = '{a: 4'd5, b: 4'd7, c0: k[0], m: k[1], s: k[5:2]};
         step(v, k == 30);
         if (k == 30) begin
            check("sweep_reset_F", {4'b0000, F}, 8'h00);
            check("sweep_reset_flags", {4'b0000, C4, AequB, P, G}, 8'h0B);
         end
      end

      for (int k = 0; k < 400; k++) begin
         r     = $urandom;
         v     = r[13:0];
         r_rst = ($urandom_range(0, 39) == 0);
         step(v, r_rst);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
